wd_id_field_parser: RTL and testbench

Downstream consumer of the byte decoder's data_buffer/data_valid stream. After an address-mark strobe it parses a WD1010-format ID field: identifier byte, cylinder low, SDH, sector number, and 2 CRC bytes. It checks CRC-16/CCITT and presents cylinder/head/sector/size/bad-block with a one-cycle result strobe. The result feeds the sector-match and read-gate logic.

---
 rtl/wd_id_field_parser_pkg.sv | 37 +++
 rtl/wd_id_field_parser_crc.sv | 24 ++
 rtl/wd_id_field_parser.sv | 141 ++++++++++++++
 tb/tb_wd_id_field_parser.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/wd_id_field_parser_pkg.sv
// Shared definitions for the WD1010 ID-field parser and its CRC helper.
// State encoding, identifier bytes, CRC polynomial and SDH bit positions.
package wd_id_field_parser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_IDENT  = 3'd1,
        ST_CYL_LO = 3'd2,
        ST_SDH    = 3'd3,
        ST_SECNUM = 3'd4,
        ST_CRC_HI = 3'd5,
        ST_CRC_LO = 3'd6
    } state_e;

    // Identifier byte values; each encodes cylinder bits [9:8]
    localparam logic [7:0] ID_CYL0 = 8'hFE;
    localparam logic [7:0] ID_CYL1 = 8'hFF;
    localparam logic [7:0] ID_CYL2 = 8'hFC;
    localparam logic [7:0] ID_CYL3 = 8'hFD;

    localparam logic [15:0] CRC_POLY = 16'h1021;

    localparam int unsigned SDH_BAD_BIT  = 7;
    localparam int unsigned SDH_SIZE_MSB = 6;
    localparam int unsigned SDH_SIZE_LSB = 5;
    localparam int unsigned SDH_HEAD_MSB = 2;
    localparam int unsigned SDH_HEAD_LSB = 0;

    typedef struct packed {
        logic [9:0] cylinder;
        logic [2:0] head;
        logic [7:0] sector;
        logic [1:0] size_code;
        logic       bad_block;
    } id_fields_t;

endpackage

// File: rtl/wd_id_field_parser_crc.sv
// Byte-wide CRC-16/CCITT update, MSB first, purely combinational.
// Shared with the data-field checker.
module crc16_ccitt_byte
    import wd_id_field_parser_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  byte_in,
    output logic [15:0] crc_out
);

    logic [15:0] crc_v;
    logic        fb;

    always_comb begin
        crc_v = crc_in;
        fb    = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            fb    = crc_v[15] ^ byte_in[i];
            crc_v = {crc_v[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end
        crc_out = crc_v;
    end

endmodule

// File: rtl/wd_id_field_parser.sv
// Parses a WD1010 ID field (ident, cyl lo, SDH, sector, CRC hi/lo) after an
// address mark and reports the decoded fields with a one-cycle result strobe.
module wd_id_field_parser
    import wd_id_field_parser_pkg::*;
#(
    parameter int unsigned BYTE_TIMEOUT = 255,
    parameter logic [15:0] CRC_PRESET   = 16'hFFFF
) (
    input  logic       clk_50,
    input  logic       reset_n,
    input  logic [7:0] data_in,
    input  logic       data_stb,
    input  logic       mark_stb,
    output logic [9:0] cylinder,
    output logic [2:0] head,
    output logic [7:0] sector,
    output logic [1:0] size_code,
    output logic       bad_block,
    output logic       id_valid,
    output logic       crc_error,
    output logic       abort,
    output logic       busy
);

    localparam int unsigned TMR_W = $clog2(BYTE_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(BYTE_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [15:0]      crc_q, crc_d, crc_sel, crc_upd;
    logic [TMR_W-1:0] timer_q, timer_d;
    id_fields_t       pend_q, pend_d, out_q, out_d;
    logic             id_valid_q, id_valid_d;
    logic             crc_error_q, crc_error_d;
    logic             abort_q, abort_d;

    // A mark byte always starts from the preset, whatever state we are in
    assign crc_sel = (data_stb && mark_stb) ? CRC_PRESET : crc_q;

    crc16_ccitt_byte u_crc (
        .crc_in  (crc_sel),
        .byte_in (data_in),
        .crc_out (crc_upd)
    );

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            crc_q       <= CRC_PRESET;
            timer_q     <= '0;
            pend_q      <= '0;
            out_q       <= '0;
            id_valid_q  <= 1'b0;
            crc_error_q <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            timer_q     <= timer_d;
            pend_q      <= pend_d;
            out_q       <= out_d;
            id_valid_q  <= id_valid_d;
            crc_error_q <= crc_error_d;
            abort_q     <= abort_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        pend_d      = pend_q;
        out_d       = out_q;
        id_valid_d  = 1'b0;
        crc_error_d = 1'b0;
        abort_d     = 1'b0;
        timer_d     = (state_q == ST_IDLE || data_stb) ? '0 : timer_q + TMR_W'(1);

        if (data_stb && mark_stb) begin
            crc_d   = crc_upd;
            state_d = ST_IDENT;
        end else if (state_q != ST_IDLE) begin
            if (data_stb) begin
                crc_d = crc_upd;
                case (state_q)
                    ST_IDENT: begin
                        state_d = ST_CYL_LO;
                        case (data_in)
                            ID_CYL0: pend_d.cylinder[9:8] = 2'd0;
                            ID_CYL1: pend_d.cylinder[9:8] = 2'd1;
                            ID_CYL2: pend_d.cylinder[9:8] = 2'd2;
                            ID_CYL3: pend_d.cylinder[9:8] = 2'd3;
                            default: begin
                                abort_d = 1'b1;
                                state_d = ST_IDLE;
                            end
                        endcase
                    end
                    ST_CYL_LO: begin
                        pend_d.cylinder[7:0] = data_in;
                        state_d              = ST_SDH;
                    end
                    ST_SDH: begin
                        pend_d.bad_block = data_in[SDH_BAD_BIT];
                        pend_d.size_code = data_in[SDH_SIZE_MSB:SDH_SIZE_LSB];
                        pend_d.head      = data_in[SDH_HEAD_MSB:SDH_HEAD_LSB];
                        state_d          = ST_SECNUM;
                    end
                    ST_SECNUM: begin
                        pend_d.sector = data_in;
                        state_d       = ST_CRC_HI;
                    end
                    ST_CRC_HI: state_d = ST_CRC_LO;
                    ST_CRC_LO: begin
                        // Zero residue after both CRC bytes means the field is intact
                        state_d = ST_IDLE;
                        if (crc_upd == 16'h0000) begin
                            id_valid_d = 1'b1;
                            out_d      = pend_q;
                        end else begin
                            crc_error_d = 1'b1;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end else if (timer_q == TMO_LAST) begin
                abort_d = 1'b1;
                state_d = ST_IDLE;
            end
        end
    end

    assign cylinder  = out_q.cylinder;
    assign head      = out_q.head;
    assign sector    = out_q.sector;
    assign size_code = out_q.size_code;
    assign bad_block = out_q.bad_block;
    assign id_valid  = id_valid_q;
    assign crc_error = crc_error_q;
    assign abort     = abort_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wd_id_field_parser.sv
// Directed self-checking bench for wd_id_field_parser.
module tb_wd_id_field_parser;

    logic       clk_50;
    logic       reset_n;
    logic [7:0] data_in;
    logic       data_stb;
    logic       mark_stb;
    logic [9:0] cylinder;
    logic [2:0] head;
    logic [7:0] sector;
    logic [1:0] size_code;
    logic       bad_block;
    logic       id_valid;
    logic       crc_error;
    logic       abort;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int valid_cnt = 0;
    int abort_cnt = 0;
    int snap_valid, snap_abort;
    logic [15:0] fcrc;

    wd_id_field_parser #(.BYTE_TIMEOUT(255), .CRC_PRESET(16'hFFFF)) dut (
        .clk_50    (clk_50),
        .reset_n   (reset_n),
        .data_in   (data_in),
        .data_stb  (data_stb),
        .mark_stb  (mark_stb),
        .cylinder  (cylinder),
        .head      (head),
        .sector    (sector),
        .size_code (size_code),
        .bad_block (bad_block),
        .id_valid  (id_valid),
        .crc_error (crc_error),
        .abort     (abort),
        .busy      (busy)
    );

    initial clk_50 = 1'b0;
    always #10 clk_50 = ~clk_50;

    always @(posedge clk_50) begin
        if (id_valid) valid_cnt <= valid_cnt + 1;
        if (abort)    abort_cnt <= abort_cnt + 1;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference CRC in the xor-then-shift form
    function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int k = 0; k < 8; k++)
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    function automatic logic [15:0] field_crc(input logic [7:0] id, input logic [7:0] cl,
                                              input logic [7:0] sdh, input logic [7:0] sec);
        logic [15:0] c;
        c = crc_model(16'hFFFF, 8'hA1);
        c = crc_model(c, id);
        c = crc_model(c, cl);
        c = crc_model(c, sdh);
        c = crc_model(c, sec);
        return c;
    endfunction

    // Called at a negedge; returns at the negedge after the sampling edge
    task automatic send_byte(input logic [7:0] b, input logic mark);
        data_in  = b;
        data_stb = 1'b1;
        mark_stb = mark;
        @(negedge clk_50);
        data_stb = 1'b0;
        mark_stb = 1'b0;
        data_in  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_50);
    endtask

    task automatic send_field(input logic [7:0] id, input logic [7:0] cl, input logic [7:0] sdh,
                              input logic [7:0] sec, input logic [7:0] flip, input int gap);
        logic [15:0] c;
        c = field_crc(id, cl, sdh, sec);
        send_byte(8'hA1, 1'b1);
        idle(gap); send_byte(id, 1'b0);
        idle(gap); send_byte(cl, 1'b0);
        idle(gap); send_byte(sdh, 1'b0);
        idle(gap); send_byte(sec, 1'b0);
        idle(gap); send_byte(c[15:8], 1'b0);
        idle(gap); send_byte(c[7:0] ^ flip, 1'b0);
    endtask

    initial begin
        reset_n  = 1'b0;
        data_in  = 8'h00;
        data_stb = 1'b0;
        mark_stb = 1'b0;
        idle(2);
        chk("rst_id_valid", 16'(id_valid), 16'h0);
        chk("rst_crc_error", 16'(crc_error), 16'h0);
        chk("rst_abort", 16'(abort), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_cylinder", 16'(cylinder), 16'h0);
        reset_n = 1'b1;
        idle(2);

        // FD ident, cyl_lo FF, SDH 80 -> cylinder 3FF, bad block
        send_field(8'hFD, 8'hFF, 8'h80, 8'h11, 8'h00, 3);
        chk("fd_id_valid", 16'(id_valid), 16'h1);
        chk("fd_cylinder", 16'(cylinder), 16'h3FF);
        chk("fd_bad_block", 16'(bad_block), 16'h1);
        chk("fd_head", 16'(head), 16'h0);
        chk("fd_sector", 16'(sector), 16'h11);
        idle(3);

        // Good field FE 2A 25 07, strobes 80 cycles apart
        send_field(8'hFE, 8'h2A, 8'h25, 8'h07, 8'h00, 80);
        chk("good_id_valid", 16'(id_valid), 16'h1);
        chk("good_crc_error", 16'(crc_error), 16'h0);
        chk("good_abort", 16'(abort), 16'h0);
        chk("good_cylinder", 16'(cylinder), 16'd42);
        chk("good_head", 16'(head), 16'd5);
        chk("good_size", 16'(size_code), 16'd1);
        chk("good_sector", 16'(sector), 16'd7);
        chk("good_bad_block", 16'(bad_block), 16'h0);
        idle(1);
        chk("good_busy_after", 16'(busy), 16'h0);
        chk("good_valid_pulse", 16'(id_valid), 16'h0);
        idle(2);

        // Same field, CRC lo corrupted
        send_field(8'hFE, 8'h2A, 8'h25, 8'h07, 8'h01, 5);
        chk("bad_crc_error", 16'(crc_error), 16'h1);
        chk("bad_crc_id_valid", 16'(id_valid), 16'h0);
        chk("bad_crc_abort", 16'(abort), 16'h0);
        chk("bad_crc_hold_cyl", 16'(cylinder), 16'd42);
        chk("bad_crc_hold_head", 16'(head), 16'd5);
        chk("bad_crc_hold_sec", 16'(sector), 16'd7);
        idle(1);
        chk("bad_crc_pulse", 16'(crc_error), 16'h0);
        idle(2);

        // Illegal identifier
        send_byte(8'hA1, 1'b1);
        send_byte(8'hFB, 1'b0);
        chk("ident_abort", 16'(abort), 16'h1);
        chk("ident_busy", 16'(busy), 16'h0);
        chk("ident_id_valid", 16'(id_valid), 16'h0);
        idle(1);
        chk("ident_abort_pulse", 16'(abort), 16'h0);
        send_field(8'hFF, 8'h10, 8'h4B, 8'h22, 8'h00, 2);
        chk("post_abort_valid", 16'(id_valid), 16'h1);
        chk("post_abort_cyl", 16'(cylinder), 16'h110);
        chk("post_abort_head", 16'(head), 16'd3);
        chk("post_abort_size", 16'(size_code), 16'd2);
        chk("post_abort_sec", 16'(sector), 16'h22);
        idle(2);

        // Timeout: abort exactly 255 cycles after the FE strobe
        send_byte(8'hA1, 1'b1);
        send_byte(8'hFE, 1'b0);
        idle(254);
        chk("tmo_early", 16'(abort), 16'h0);
        chk("tmo_busy_before", 16'(busy), 16'h1);
        idle(1);
        chk("tmo_abort", 16'(abort), 16'h1);
        chk("tmo_busy", 16'(busy), 16'h0);
        idle(2);

        // New mark while SDH is expected restarts cleanly
        snap_valid = valid_cnt;
        snap_abort = abort_cnt;
        send_byte(8'hA1, 1'b1);
        send_byte(8'hFE, 1'b0);
        send_byte(8'h2A, 1'b0);
        send_field(8'hFC, 8'h05, 8'hA2, 8'h03, 8'h00, 4);
        chk("restart_valid", 16'(id_valid), 16'h1);
        chk("restart_cyl", 16'(cylinder), 16'h205);
        chk("restart_head", 16'(head), 16'd2);
        chk("restart_size", 16'(size_code), 16'd1);
        chk("restart_bad", 16'(bad_block), 16'h1);
        chk("restart_sec", 16'(sector), 16'h03);
        idle(1);
        chk("restart_valid_cnt", 16'(valid_cnt - snap_valid), 16'd1);
        chk("restart_abort_cnt", 16'(abort_cnt - snap_abort), 16'd0);
        idle(2);

        // Async reset while waiting for CRC hi
        fcrc = field_crc(8'hFE, 8'h2A, 8'h25, 8'h07);
        send_byte(8'hA1, 1'b1);
        send_byte(8'hFE, 1'b0);
        send_byte(8'h2A, 1'b0);
        send_byte(8'h25, 1'b0);
        send_byte(8'h07, 1'b0);
        idle(3);
        chk("arst_busy_before", 16'(busy), 16'h1);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_busy", 16'(busy), 16'h0);
        chk("arst_cylinder", 16'(cylinder), 16'h0);
        chk("arst_head", 16'(head), 16'h0);
        chk("arst_sector", 16'(sector), 16'h0);
        chk("arst_bad_block", 16'(bad_block), 16'h0);
        snap_valid = valid_cnt;
        @(negedge clk_50);
        reset_n = 1'b1;
        idle(1);
        send_byte(fcrc[15:8], 1'b0);
        send_byte(fcrc[7:0], 1'b0);
        chk("arst_no_valid", 16'(id_valid), 16'h0);
        idle(2);
        chk("arst_valid_cnt", 16'(valid_cnt - snap_valid), 16'd0);
        chk("arst_busy_after", 16'(busy), 16'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
